// File: rtl/decode_stage_pipe.sv
// LEGv8 instruction-decode stage: register file with write-through, class decode,
// immediate sign-extension, load-use stall and flush, registered into an ID/EX stage.
module decode_stage_pipe #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int NREGS  = 32,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [RIDX_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [ADDR_W-1:0] ex_pc,
    output logic [31:0]       ex_instr,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [RIDX_W-1:0] ex_rd,
    output logic [5:0]        ex_ctrl
);

    localparam logic [RIDX_W-1:0] XZR     = RIDX_W'(NREGS - 1);
    localparam logic [RIDX_W:0]   NREGS_W = (RIDX_W + 1)'(NREGS);

    // ex_ctrl bit positions: {rtype, ldur, stur, b, cbz, cbnz}
    localparam int C_RTYPE = 5;
    localparam int C_LDUR  = 4;
    localparam int C_STUR  = 3;
    localparam int C_B     = 2;
    localparam int C_CBZ   = 1;
    localparam int C_CBNZ  = 0;

    logic [DATA_W-1:0] regs [NREGS];

    logic [10:0]       op11;
    logic [5:0]        dec_ctrl;
    logic [RIDX_W-1:0] rn_idx;
    logic [RIDX_W-1:0] src2_idx;
    logic [RIDX_W-1:0] rd_idx;
    logic [DATA_W-1:0] dec_imm;
    logic [DATA_W-1:0] rd1_val;
    logic [DATA_W-1:0] rd2_val;

    logic load_pending;
    logic rn_used;
    logic src2_used;
    logic hazard;
    logic free;
    logic accept;

    // XZR and any index beyond the implemented file read as zero; a same-cycle
    // write to the index is forwarded so writeback never costs a bubble.
    function automatic logic [DATA_W-1:0] rf_read(input logic [RIDX_W-1:0] idx);
        logic [DATA_W-1:0] val;
        val = '0;
        if (idx != XZR && {1'b0, idx} < NREGS_W) begin
            if (wb_en && wb_addr == idx)
                val = wb_data;
            else
                val = regs[idx];
        end
        return val;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb_en && wb_addr != XZR && {1'b0, wb_addr} < NREGS_W) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign op11   = if_instr[31:21];
    assign rn_idx = RIDX_W'(if_instr[9:5]);
    assign rd_idx = RIDX_W'(if_instr[4:0]);

    always_comb begin
        dec_ctrl          = '0;
        dec_ctrl[C_RTYPE] = (op11 == 11'b10001011000) || (op11 == 11'b11001011000) ||
                            (op11 == 11'b10001010000) || (op11 == 11'b10101010000);
        dec_ctrl[C_LDUR]  = (op11 == 11'b11111000010);
        dec_ctrl[C_STUR]  = (op11 == 11'b11111000000);
        dec_ctrl[C_B]     = (if_instr[31:26] == 6'b000101);
        dec_ctrl[C_CBZ]   = (if_instr[31:24] == 8'b10110100);
        dec_ctrl[C_CBNZ]  = (if_instr[31:24] == 8'b10110101);
    end

    always_comb begin
        src2_idx = RIDX_W'(if_instr[20:16]);
        if (dec_ctrl[C_STUR] || dec_ctrl[C_CBZ] || dec_ctrl[C_CBNZ])
            src2_idx = RIDX_W'(if_instr[4:0]);
    end

    always_comb begin
        dec_imm = '0;
        if (dec_ctrl[C_B])
            dec_imm = {{(DATA_W-26){if_instr[25]}}, if_instr[25:0]};
        else if (dec_ctrl[C_CBZ] || dec_ctrl[C_CBNZ])
            dec_imm = {{(DATA_W-19){if_instr[23]}}, if_instr[23:5]};
        else if (dec_ctrl[C_LDUR] || dec_ctrl[C_STUR])
            dec_imm = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
    end

    assign rd1_val = rf_read(rn_idx);
    assign rd2_val = rf_read(src2_idx);

    // A load to XZR produces nothing a consumer can depend on, so it never stalls.
    assign load_pending = ex_valid && ex_ctrl[C_LDUR] && (ex_rd != XZR);
    assign rn_used      = (dec_ctrl[C_RTYPE] || dec_ctrl[C_LDUR] || dec_ctrl[C_STUR]) &&
                          (rn_idx == ex_rd);
    assign src2_used    = (dec_ctrl[C_RTYPE] || dec_ctrl[C_STUR] ||
                           dec_ctrl[C_CBZ] || dec_ctrl[C_CBNZ]) && (src2_idx == ex_rd);
    assign hazard       = load_pending && if_valid && (rn_used || src2_used);

    assign free     = !ex_valid || ex_ready;
    assign if_ready = !reset && (flush || (free && !hazard));
    assign accept   = if_valid && if_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_instr <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_imm   <= '0;
            ex_rd    <= '0;
            ex_ctrl  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_pc    <= if_pc;
            ex_instr <= if_instr;
            ex_rd1   <= rd1_val;
            ex_rd2   <= rd2_val;
            ex_imm   <= dec_imm;
            ex_rd    <= rd_idx;
            ex_ctrl  <= dec_ctrl;
        end else if (free) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Clocked, parametrised LEGv8 instruction-decode pipeline stage with valid/ready handshakes on both sides.
- Sits between fetch and execution. It contains the architectural register file, with a write port fed from writeback and XZR hardwired to zero.
- Decodes opcode class, selects the second source register, sign-extends the immediate, and registers all results into an ID/EX output register.
- Adds synchronous writeback with same-cycle write-through, load-use stall insertion, and branch flush.

Parameters:
- DATA_W, 64, register and data width in bits.
- ADDR_W, 64, program counter width.
- NREGS, 32, number of architectural registers; index NREGS-1 is XZR.
- RIDX_W, 5, register index width; must satisfy 2**RIDX_W >= NREGS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  decode accepts the instruction this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  ADDR_W  address of if_instr.
- flush  in  1  taken branch; kill the output register and the incoming instruction.
- wb_en  in  1  register-file write enable.
- wb_addr  in  RIDX_W  write index.
- wb_data  in  DATA_W  write data.
- ex_valid  out  1  output register holds a live instruction.
- ex_ready  in  1  execution consumes the output register this cycle.
- ex_pc  out  ADDR_W  registered PC.
- ex_instr  out  32  registered instruction.
- ex_rd1  out  DATA_W  operand from Rn, Instruction[9:5].
- ex_rd2  out  DATA_W  operand from the selected second source.
- ex_imm  out  DATA_W  sign-extended immediate, unshifted.
- ex_rd  out  RIDX_W  destination / Rt, Instruction[4:0].
- ex_ctrl  out  6  one-hot class: {rtype, ldur, stur, b, cbz, cbnz}; all zero means NOP/unknown.

Behaviour:
- Reset:
  - ex_valid=0 and every ex_* output = 0.
  - All NREGS registers cleared to 0 in that cycle.
  - if_ready=0 while reset is high.
- Decode classes:
  - B: Instruction[31:26]=000101.
  - CBZ: Instruction[31:24]=10110100.
  - CBNZ: Instruction[31:24]=10110101.
  - LDUR: Instruction[31:21]=11111000010.
  - STUR: Instruction[31:21]=11111000000.
  - R-type: Instruction[31:21] in {10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR}.
  - Anything else decodes to ex_ctrl=0 and still passes through.
- Second source select:
  - STUR, CBZ, CBNZ read Instruction[4:0].
  - All other classes read Instruction[20:16].
  - The full DATA_W value is read in every case; no partial writes.
- Immediate, sign-extended to DATA_W:
  - B: Instruction[25:0].
  - CBZ/CBNZ: Instruction[23:5].
  - LDUR/STUR: Instruction[20:12].
  - All other classes: 0.
- Register read:
  - Index NREGS-1 always reads 0.
  - If wb_en and wb_addr equals the read index (and the index is not NREGS-1), the read returns wb_data in the same cycle (write-through).
  - Writes to NREGS-1 are ignored.
  - The write commits at the clock edge, independent of stalls and flushes.
- Handshake:
  - Output register "free" = !ex_valid || ex_ready.
  - if_ready = free && !hazard && !reset, or flush (see below).
  - On if_valid && if_ready && !flush: the output register loads the decoded instruction and ex_valid=1.
  - Free with no accept: ex_valid=0 (bubble).
  - Not free: hold all ex_* outputs stable.
- Load-use hazard:
  - Hazard = ex_valid && ex_ctrl.ldur && ex_rd != NREGS-1 && if_valid && an incoming source uses ex_rd.
  - An incoming source uses ex_rd if (incoming reads Rn: classes rtype/ldur/stur, and Instruction[9:5]==ex_rd) or (incoming second source index == ex_rd, for classes rtype/stur/cbz/cbnz).
  - During a hazard, if_ready=0. When ex_ready is high, a bubble is inserted, giving exactly one stall cycle. The next cycle accepts the instruction.
- Flush:
  - Highest priority after reset.
  - Next edge: ex_valid=0.
  - if_ready=1 during flush; the incoming instruction is consumed and discarded.
- Latency: exactly one cycle from acceptance to ex_valid.
- Throughput: one instruction per cycle when ex_ready stays high and there are no hazards.

Test Plan:
- Reset, then wb write X1=0x5 and X2=0x7, then ADD X3,X1,X2 (0x8B020023) -> next cycle ex_valid=1, ex_rd1=5, ex_rd2=7, ex_ctrl=rtype, ex_rd=3.
- wb_en=1, wb_addr=4, wb_data=0xAA in the same cycle as STUR X4,[X5,#-8] is accepted -> ex_rd2=0xAA, ex_imm=0xFFFF_FFFF_FFFF_FFF8, ex_ctrl=stur.
- LDUR X9,[X1,#0] followed by ADD X10,X9,X2 -> if_ready=0 for one cycle and one bubble (ex_valid=0), then ADD is issued. Repeat with ADD X10,X2,X3: no stall.
- ex_ready held 0 for 3 cycles with a valid output -> ex_* outputs stable and if_ready=0; the instruction pending on if_instr is accepted on the first cycle ex_ready=1.
- flush=1 while the output holds B (imm26 = all ones) and if_valid=1 -> if_ready=1, next cycle ex_valid=0. A B accepted without flush has ex_imm=-1.
- wb write X31=0x123, then CBZ X31 -> ex_rd2=0. Assert reset mid-stream -> ex_valid=0, then X1 reads 0.
